// File: rtl/elevator_request_latch.sv
// Call-button front end for the elevator controller: synchronises and debounces
// four floor buttons, latches presses as pending requests and clears them on service.
module elevator_request_latch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] floor,
  input  logic       door,
  output logic [3:0] req,
  output logic [3:0] press_pulse,
  output logic [2:0] pending_cnt
);

  localparam int unsigned NUM_FLOORS = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       db;
  logic [CNT_W-1:0] cnt [NUM_FLOORS];

  logic [3:0]       db_next;
  logic [CNT_W-1:0] cnt_next [NUM_FLOORS];
  logic [3:0]       rise;
  logic [3:0]       svc;
  logic [3:0]       req_next;
  logic [2:0]       pending_next;

  // Debounce, press detect, service clear and request update for every floor.
  always_comb begin
    db_next      = db;
    rise         = '0;
    svc          = '0;
    req_next     = req;
    pending_next = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = ~db[i];
          rise[i]    = ~db[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
      svc[i] = door && (floor == 2'(i));
      // A press arriving while the cab already serves that floor is dropped.
      if (svc[i]) begin
        req_next[i] = 1'b0;
      end else if (rise[i]) begin
        req_next[i] = 1'b1;
      end
      pending_next = pending_next + 3'(req_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      db          <= '0;
      req         <= '0;
      press_pulse <= '0;
      pending_cnt <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= btn;
      s2          <= s1;
      db          <= db_next;
      req         <= req_next;
      press_pulse <= req_next & ~req;
      pending_cnt <= pending_next;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Bench for elevator_request_latch: directed vector table, hand-written corner
// sequences and randomized traffic against a history-based reference model.
module tb_elevator_request_latch;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] floor;
  logic       door;
  logic [3:0] req;
  logic [3:0] press_pulse;
  logic [2:0] pending_cnt;

  int n_cmp;
  int n_bad;

  elevator_request_latch #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .btn(btn), .floor(floor), .door(door),
    .req(req), .press_pulse(press_pulse), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] floor;
    logic       door;
    logic [3:0] req;
    logic [3:0] pulse;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the debounced level flips once the last DEB synchronised
  // samples all disagree with it.
  logic [3:0] m_s1, m_s2, m_db, m_req, m_pulse;
  logic [2:0] m_cnt;
  logic [3:0] m_hist [DEB];

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_req = '0; m_pulse = '0; m_cnt = '0;
    for (int j = 0; j < DEB; j++) m_hist[j] = '0;
  endfunction

  function automatic void model_edge();
    logic [3:0] new_req;
    for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = m_s2;
    new_req = m_req;
    for (int i = 0; i < 4; i++) begin
      bit all_diff;
      bit pressed;
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (m_hist[j][i] == m_db[i]) all_diff = 1'b0;
      pressed = all_diff && !m_db[i];
      if (all_diff) m_db[i] = ~m_db[i];
      if (door && int'(floor) == i) new_req[i] = 1'b0;
      else if (pressed) new_req[i] = 1'b1;
    end
    m_pulse = new_req & ~m_req;
    m_req   = new_req;
    m_cnt   = 3'($countones(new_req));
    m_s2    = m_s1;
    m_s1    = btn;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn = '0; floor = '0; door = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic add(input int n, input logic [3:0] b, input logic [1:0] f, input logic d,
                     input logic [3:0] r, input logic [3:0] p, input logic [2:0] c);
    vec_t v;
    v.btn = b; v.floor = f; v.door = d; v.req = r; v.pulse = p; v.cnt = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    int first;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    btn = '0; floor = '0; door = 1'b0;
    model_reset();
    #2;
    check("reset_req", req, 4'b0000);
    check("reset_pulse", press_pulse, 4'b0000);
    check("reset_cnt", {1'b0, pending_cnt}, 4'd0);
    do_reset();

    // Clean press on floor 3, then long hold.
    add(5,  4'b1000, 2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0);
    add(1,  4'b1000, 2'd0, 1'b0, 4'b1000, 4'b1000, 3'd1);
    add(10, 4'b1000, 2'd0, 1'b0, 4'b1000, 4'b0000, 3'd1);
    // Floors 0 and 2 pressed, then serviced one at a time.
    add(5,  4'b1101, 2'd0, 1'b0, 4'b1000, 4'b0000, 3'd1);
    add(1,  4'b1101, 2'd0, 1'b0, 4'b1101, 4'b0101, 3'd3);
    add(1,  4'b1101, 2'd2, 1'b1, 4'b1001, 4'b0000, 3'd2);
    add(1,  4'b1101, 2'd0, 1'b1, 4'b1000, 4'b0000, 3'd1);
    add(1,  4'b1101, 2'd0, 1'b0, 4'b1000, 4'b0000, 3'd1);
    add(1,  4'b0000, 2'd3, 1'b1, 4'b0000, 4'b0000, 3'd0);
    add(6,  4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0);
    // Press at the open-door floor is dropped; floor 3 latches meanwhile.
    add(5,  4'b1010, 2'd1, 1'b1, 4'b0000, 4'b0000, 3'd0);
    add(1,  4'b1010, 2'd1, 1'b1, 4'b1000, 4'b1000, 3'd1);
    add(2,  4'b1010, 2'd1, 1'b1, 4'b1000, 4'b0000, 3'd1);
    add(6,  4'b0000, 2'd1, 1'b0, 4'b1000, 4'b0000, 3'd1);
    add(5,  4'b0010, 2'd0, 1'b0, 4'b1000, 4'b0000, 3'd1);
    add(1,  4'b0010, 2'd0, 1'b0, 4'b1010, 4'b0010, 3'd2);
    add(1,  4'b0000, 2'd1, 1'b1, 4'b1000, 4'b0000, 3'd1);
    add(1,  4'b0000, 2'd3, 1'b1, 4'b0000, 4'b0000, 3'd0);
    add(6,  4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0);
    // All floors at once, then re-press of an already pending floor.
    add(5,  4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0000, 3'd0);
    add(1,  4'b1111, 2'd0, 1'b0, 4'b1111, 4'b1111, 3'd4);
    add(2,  4'b1111, 2'd0, 1'b0, 4'b1111, 4'b0000, 3'd4);
    add(6,  4'b1011, 2'd0, 1'b0, 4'b1111, 4'b0000, 3'd4);
    add(8,  4'b1111, 2'd0, 1'b0, 4'b1111, 4'b0000, 3'd4);

    for (int k = 0; k < vecs.size(); k++) begin
      btn = vecs[k].btn; floor = vecs[k].floor; door = vecs[k].door;
      step();
      check($sformatf("vec%0d_req", k), req, vecs[k].req);
      check($sformatf("vec%0d_pulse", k), press_pulse, vecs[k].pulse);
      check($sformatf("vec%0d_cnt", k), {1'b0, pending_cnt}, {1'b0, vecs[k].cnt});
    end

    // Short glitches never latch; bouncing then a clean hold latches 6 edges after the final rise.
    do_reset();
    for (int g = 0; g < 3; g++) begin
      btn = 4'b0010;
      repeat (3) step();
      btn = 4'b0000;
      repeat (4) step();
      check("glitch_req", req, 4'b0000);
    end
    for (int b = 0; b < 4; b++) begin
      btn = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      step();
      check("bounce_req", req, 4'b0000);
    end
    btn = 4'b0010;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (first == 0 && req[1]) begin
        first = e;
        check("bounce_pulse", press_pulse, 4'b0010);
      end
    end
    check("bounce_latency", 4'(first), 4'd6);

    // Asynchronous reset mid-debounce, with a held button across release.
    btn = 4'b0110;
    repeat (6) step();
    check("prereset_req", req, 4'b0110);
    btn = 4'b0111;
    repeat (3) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_req", req, 4'b0000);
    check("async_pulse", press_pulse, 4'b0000);
    check("async_cnt", {1'b0, pending_cnt}, 4'd0);
    btn = 4'b0001;
    repeat (2) step();
    reset = 1'b0;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (first == 0 && req[0]) first = e;
    end
    check("held_latency", 4'(first), 4'd6);
    check("held_req", req, 4'b0001);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      floor = 2'($urandom_range(0, 3));
      door  = ($urandom_range(0, 7) == 0);
      step();
      check("rand_req", req, m_req);
      check("rand_pulse", press_pulse, m_pulse);
      check("rand_cnt", {1'b0, pending_cnt}, {1'b0, m_cnt});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
